// File: rtl/rom_prefetch_queue.sv
// rtl/rom_prefetch_queue.sv - sliding-window ROM prefetch queue in front of the QSPI flash stream (optional stats: ROM_PREFETCH_STATS_EN)
module rom_prefetch_queue #(
    parameter int                         ADDR_BITS       = 12,
    parameter int                         FLASH_ADDR_BITS = 24,
    parameter logic [FLASH_ADDR_BITS-1:0] FLASH_BASE      = 24'h100000,
    parameter int                         DEPTH           = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       rom_req,
    input  logic [ADDR_BITS-1:0]       rom_addr,
    output logic [7:0]                 rom_data,
    output logic                       rom_wait,
    output logic [FLASH_ADDR_BITS-1:0] fl_addr,
    output logic                       fl_start,
    output logic                       fl_stop,
    output logic                       fl_stall,
    input  logic [7:0]                 fl_data,
    input  logic                       fl_ready,
`ifdef ROM_PREFETCH_STATS_EN
    output logic [15:0]                stat_hits,
    output logic [15:0]                stat_misses,
`endif
    input  logic                       fl_busy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_STOP} state_t;

    state_t                     state_q, state_d;
    logic [ADDR_BITS-1:0]       base_q, base_d;
    logic [CW-1:0]              count_q, count_d;
    logic [PW-1:0]              rd_ptr_q, rd_ptr_d;
    logic [ADDR_BITS-1:0]       tgt_q, tgt_d;
    logic                       tgt_vld_q, tgt_vld_d;
    logic [FLASH_ADDR_BITS-1:0] fl_addr_q, fl_addr_d;
    logic                       fl_start_q, fl_start_d;
    logic                       fl_stop_q, fl_stop_d;
    logic                       fl_stall_q, fl_stall_d;
    logic [7:0]                 mem_q [DEPTH];
    logic [7:0]                 mem_d [DEPTH];

    logic [ADDR_BITS-1:0]       offset;
    logic [ADDR_BITS-1:0]       count_a;
    logic [ADDR_BITS-1:0]       wrap_sum;
    logic [PW-1:0]              rd_idx;
    logic [PW-1:0]              wr_idx;
    logic                       in_stream;
    logic                       plain_hit;
    logic                       fill_ok;
    logic                       fwd_hit;
    logic                       hit;
    logic                       pending;
    logic                       jump;
    logic                       new_miss;
    logic                       start_en;
    logic [ADDR_BITS-1:0]       start_addr;

    // Hit detection; the byte arriving this cycle at the window tail is forwarded
    always_comb begin
        offset    = rom_addr - base_q;
        count_a   = ADDR_BITS'(count_q);
        in_stream = (state_q == S_STREAM);
        plain_hit = rom_req && (offset < count_a);
        // A full queue only accepts a byte when a hit this cycle frees a slot
        fill_ok   = fl_ready && in_stream && ((count_q != FULL) || (plain_hit && (offset != '0)));
        fwd_hit   = rom_req && fill_ok && (offset == count_a);
        hit       = plain_hit || fwd_hit;
        rom_wait  = rom_req && !hit;
        rd_idx    = rd_ptr_q + PW'(offset);
        wr_idx    = rd_ptr_q + PW'(count_q);
        rom_data  = fwd_hit ? fl_data : mem_q[rd_idx];
        // Waiting on the next streamed byte is not a jump; a full queue cannot deliver it
        pending   = in_stream && (offset == count_a) && (count_q != FULL);
        jump      = rom_wait && in_stream && !pending;
        case (state_q)
            S_IDLE:   new_miss = rom_wait;
            S_STREAM: new_miss = jump;
            default:  new_miss = rom_wait && (!tgt_vld_q || (rom_addr != tgt_q));
        endcase
    end

    // Window update, fill and flash-stream FSM next state
    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        tgt_d      = tgt_q;
        tgt_vld_d  = tgt_vld_q;
        fl_addr_d  = fl_addr_q;
        fl_start_d = 1'b0;
        fl_stop_d  = 1'b0;
        mem_d      = mem_q;
        start_en   = 1'b0;
        start_addr = tgt_q;
        wrap_sum   = '0;

        if (hit) begin
            base_d   = rom_addr;
            count_d  = count_q - CW'(offset);
            rd_ptr_d = rd_idx;
        end
        if (fill_ok && !jump) begin
            mem_d[wr_idx] = fl_data;
            count_d       = count_d + CW'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (rom_wait) begin
                    if (!fl_busy) begin
                        start_en   = 1'b1;
                        start_addr = rom_addr;
                    end else begin
                        tgt_d     = rom_addr;
                        tgt_vld_d = 1'b1;
                        state_d   = S_STOP;
                    end
                end
            end
            S_STREAM: begin
                wrap_sum = base_d + ADDR_BITS'(count_d);
                if (jump) begin
                    tgt_d     = rom_addr;
                    tgt_vld_d = 1'b1;
                    fl_stop_d = 1'b1;
                    base_d    = rom_addr;
                    count_d   = '0;
                    state_d   = S_STOP;
                end else if (fill_ok && (wrap_sum == '0)) begin
                    // Stream crossed the top of ROM space; keep what we have
                    fl_stop_d = 1'b1;
                    tgt_vld_d = 1'b0;
                    state_d   = S_STOP;
                end
            end
            default: begin
                if (rom_wait) begin
                    tgt_d     = rom_addr;
                    tgt_vld_d = 1'b1;
                end
                if (!fl_busy) begin
                    if (rom_wait) begin
                        start_en   = 1'b1;
                        start_addr = rom_addr;
                    end else if (tgt_vld_q) begin
                        start_en   = 1'b1;
                        start_addr = tgt_q;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
        endcase

        if (start_en) begin
            fl_start_d = 1'b1;
            fl_addr_d  = FLASH_BASE + FLASH_ADDR_BITS'(start_addr);
            base_d     = start_addr;
            count_d    = '0;
            tgt_vld_d  = 1'b0;
            state_d    = S_STREAM;
        end

        fl_stall_d = (count_d == FULL);
    end

    // State registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            base_q     <= '0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            tgt_q      <= '0;
            tgt_vld_q  <= 1'b0;
            fl_addr_q  <= FLASH_BASE;
            fl_start_q <= 1'b0;
            fl_stop_q  <= 1'b0;
            fl_stall_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            tgt_q      <= tgt_d;
            tgt_vld_q  <= tgt_vld_d;
            fl_addr_q  <= fl_addr_d;
            fl_start_q <= fl_start_d;
            fl_stop_q  <= fl_stop_d;
            fl_stall_q <= fl_stall_d;
        end
    end

    // Queue storage needs no reset; count gates validity
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign fl_addr  = fl_addr_q;
    assign fl_start = fl_start_q;
    assign fl_stop  = fl_stop_q;
    assign fl_stall = fl_stall_q;

`ifdef ROM_PREFETCH_STATS_EN
    logic [15:0] stat_hits_q, stat_hits_d;
    logic [15:0] stat_misses_q, stat_misses_d;

    // Saturating hit / miss-event counters
    always_comb begin
        stat_hits_d   = stat_hits_q;
        stat_misses_d = stat_misses_q;
        if (hit && (stat_hits_q != 16'hFFFF)) begin
            stat_hits_d = stat_hits_q + 16'd1;
        end
        if (new_miss && (stat_misses_q != 16'hFFFF)) begin
            stat_misses_d = stat_misses_q + 16'd1;
        end
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_hits_q   <= '0;
            stat_misses_q <= '0;
        end else begin
            stat_hits_q   <= stat_hits_d;
            stat_misses_q <= stat_misses_d;
        end
    end

    assign stat_hits   = stat_hits_q;
    assign stat_misses = stat_misses_q;
`else
    logic unused_miss;
    assign unused_miss = new_miss;
`endif

endmodule

// File: tb/tb_rom_prefetch_queue.sv
// tb/tb_rom_prefetch_queue.sv - scoreboard bench for rom_prefetch_queue
module tb_rom_prefetch_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rom_req;
    logic [11:0] rom_addr;
    logic [7:0]  rom_data;
    logic        rom_wait;
    logic [23:0] fl_addr;
    logic        fl_start;
    logic        fl_stop;
    logic        fl_stall;
    logic [7:0]  fl_data;
    logic        fl_ready;
    logic        fl_busy;
`ifdef ROM_PREFETCH_STATS_EN
    logic [15:0] stat_hits;
    logic [15:0] stat_misses;
`endif

    int tests = 0;
    int fails = 0;

    logic [7:0]  exp_data_q  [$];
    logic [23:0] exp_start_q [$];
    int          exp_stop_q  [$];

    rom_prefetch_queue dut (
        .clk(clk), .rst_n(rst_n),
        .rom_req(rom_req), .rom_addr(rom_addr), .rom_data(rom_data), .rom_wait(rom_wait),
        .fl_addr(fl_addr), .fl_start(fl_start), .fl_stop(fl_stop), .fl_stall(fl_stall),
        .fl_data(fl_data), .fl_ready(fl_ready),
`ifdef ROM_PREFETCH_STATS_EN
        .stat_hits(stat_hits), .stat_misses(stat_misses),
`endif
        .fl_busy(fl_busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] fbyte(input logic [11:0] a);
        return a[7:0] ^ {a[11:8], a[11:8]} ^ 8'h3C;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic req, input logic [11:0] a, input logic rdy,
                         input logic [7:0] d, input logic busy);
        rom_req  = req;
        rom_addr = a;
        fl_ready = rdy;
        fl_data  = d;
        fl_busy  = busy;
    endtask

    // Monitor: pop the expected value whenever the DUT presents a byte or a flash command
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (rom_req && !rom_wait) begin
                if (exp_data_q.size() == 0) begin
                    chk("unexpected_rom_data", {24'h0, rom_data}, 32'hFFFF_FFFF);
                end else begin
                    chk($sformatf("rom_data@%h", rom_addr), {24'h0, rom_data}, {24'h0, exp_data_q.pop_front()});
                end
            end
            if (fl_start) begin
                if (exp_start_q.size() == 0) begin
                    chk("unexpected_fl_start", {8'h0, fl_addr}, 32'hFFFF_FFFF);
                end else begin
                    chk("fl_start_addr", {8'h0, fl_addr}, {8'h0, exp_start_q.pop_front()});
                end
            end
            if (fl_stop) begin
                if (exp_stop_q.size() == 0) begin
                    chk("unexpected_fl_stop", 32'h1, 32'h0);
                end else begin
                    chk("fl_stop_seen", 32'(exp_stop_q.pop_front()), 32'h1);
                end
            end
            if (fl_start && fl_stop) begin
                chk("start_and_stop_together", 32'h1, 32'h0);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        drive(1'b1, 12'h555, 1'b0, 8'h00, 1'b0);
        repeat (3) tick();
        @(negedge clk);
        chk("reset_wait_follows_req", 32'(rom_wait), 32'h1);

        tick();
        rst_n = 1'b1;
        drive(1'b0, 12'h000, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        chk("reset_fl_addr", {8'h0, fl_addr}, 32'h0010_0000);
        chk("reset_fl_start", 32'(fl_start), 32'h0);
        chk("reset_fl_stop", 32'(fl_stop), 32'h0);
        chk("reset_fl_stall", 32'(fl_stall), 32'h0);
`ifdef ROM_PREFETCH_STATS_EN
        chk("reset_stat_hits", 32'(stat_hits), 32'h0);
        chk("reset_stat_misses", 32'(stat_misses), 32'h0);
`endif

        // Cold miss at FFC
        tick(); drive(1'b1, 12'hFFC, 1'b0, 8'h00, 1'b0);
        exp_start_q.push_back(24'h100FFC);
        exp_data_q.push_back(fbyte(12'hFFC));
        @(negedge clk);
        chk("cold_wait_c0", 32'(rom_wait), 32'h1);
        chk("cold_no_start_c0", 32'(fl_start), 32'h0);
        tick(); @(negedge clk);
        chk("cold_start_c1", 32'(fl_start), 32'h1);
        chk("cold_wait_c1", 32'(rom_wait), 32'h1);
        tick(); @(negedge clk);
        chk("cold_start_one_cycle", 32'(fl_start), 32'h0);
        chk("cold_wait_c2", 32'(rom_wait), 32'h1);
        tick(); drive(1'b1, 12'hFFC, 1'b1, fbyte(12'hFFC), 1'b0);
        @(negedge clk);
        chk("cold_wait_falls_on_ready", 32'(rom_wait), 32'h0);

        // Sequential streaming FFD, FFE
        for (int i = 1; i <= 2; i++) begin
            tick(); drive(1'b1, 12'hFFC + 12'(i), 1'b1, fbyte(12'hFFC + 12'(i)), 1'b0);
            exp_data_q.push_back(fbyte(12'hFFC + 12'(i)));
            @(negedge clk);
            chk("seq_no_wait", 32'(rom_wait), 32'h0);
            chk("seq_no_start", 32'(fl_start), 32'h0);
        end

        // Byte FFF arrives: stream wraps and stops, queue retained
        tick(); drive(1'b0, 12'h000, 1'b1, fbyte(12'hFFF), 1'b0);
        exp_stop_q.push_back(1);
        @(negedge clk);
        chk("wrap_stop_registered", 32'(fl_stop), 32'h0);
        tick(); drive(1'b1, 12'hFFF, 1'b0, 8'h00, 1'b0);
        exp_data_q.push_back(fbyte(12'hFFF));
        @(negedge clk);
        chk("wrap_stop_pulse", 32'(fl_stop), 32'h1);
        chk("wrap_retained_hit", 32'(rom_wait), 32'h0);
        tick(); drive(1'b1, 12'h000, 1'b0, 8'h00, 1'b0);
        exp_start_q.push_back(24'h100000);
        exp_data_q.push_back(fbyte(12'h000));
        @(negedge clk);
        chk("wrap_read0_miss", 32'(rom_wait), 32'h1);
        chk("wrap_stop_one_cycle", 32'(fl_stop), 32'h0);
        tick(); @(negedge clk);
        chk("wrap_restart", 32'(fl_start), 32'h1);
        tick(); drive(1'b1, 12'h000, 1'b1, fbyte(12'h000), 1'b0);
        @(negedge clk);
        chk("wrap_read0_served", 32'(rom_wait), 32'h0);

        // Fill to full (000..003 without reads)
        for (int i = 1; i <= 3; i++) begin
            tick(); drive(1'b0, 12'h000, 1'b1, fbyte(12'(i)), 1'b0);
        end
        @(negedge clk);
        chk("full_stall_low_at_3", 32'(fl_stall), 32'h0);
        tick(); drive(1'b1, 12'h002, 1'b0, 8'h00, 1'b0);
        exp_data_q.push_back(fbyte(12'h002));
        @(negedge clk);
        chk("full_stall_high", 32'(fl_stall), 32'h1);
        chk("full_hit_k2", 32'(rom_wait), 32'h0);
        tick(); drive(1'b1, 12'h003, 1'b0, 8'h00, 1'b0);
        exp_data_q.push_back(fbyte(12'h003));
        @(negedge clk);
        chk("full_stall_released", 32'(fl_stall), 32'h0);

        // Jump to 800 with a busy controller
        tick(); drive(1'b1, 12'h800, 1'b0, 8'h00, 1'b1);
        exp_stop_q.push_back(1);
        exp_start_q.push_back(24'h100800);
        exp_data_q.push_back(fbyte(12'h800));
        @(negedge clk);
        chk("jump800_wait", 32'(rom_wait), 32'h1);
        tick(); @(negedge clk);
        chk("jump800_stop", 32'(fl_stop), 32'h1);
        tick(); drive(1'b1, 12'h800, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        chk("jump800_held_while_busy", 32'(fl_start), 32'h0);
        tick(); drive(1'b1, 12'h800, 1'b0, 8'h00, 1'b1);
        @(negedge clk);
        chk("jump800_start", 32'(fl_start), 32'h1);
        tick(); drive(1'b1, 12'h800, 1'b1, fbyte(12'h800), 1'b1);
        @(negedge clk);
        chk("jump800_served", 32'(rom_wait), 32'h0);
        tick(); drive(1'b0, 12'h000, 1'b1, fbyte(12'h801), 1'b1);

        // Jump to 123 while base=800
        tick(); drive(1'b1, 12'h123, 1'b0, 8'h00, 1'b1);
        exp_stop_q.push_back(1);
        exp_start_q.push_back(24'h100123);
        exp_data_q.push_back(fbyte(12'h123));
        @(negedge clk);
        chk("jump123_wait", 32'(rom_wait), 32'h1);
        tick(); @(negedge clk);
        chk("jump123_stop", 32'(fl_stop), 32'h1);
        tick(); @(negedge clk);
        chk("jump123_no_start_busy", 32'(fl_start), 32'h0);
        tick(); drive(1'b1, 12'h123, 1'b0, 8'h00, 1'b0);
        tick(); drive(1'b1, 12'h123, 1'b0, 8'h00, 1'b1);
        @(negedge clk);
        chk("jump123_start", 32'(fl_start), 32'h1);
        chk("jump123_addr", {8'h0, fl_addr}, 32'h0010_0123);
        tick(); drive(1'b1, 12'h123, 1'b1, fbyte(12'h123), 1'b1);
        @(negedge clk);
        chk("jump123_served", 32'(rom_wait), 32'h0);
        tick(); drive(1'b0, 12'h000, 1'b1, fbyte(12'h124), 1'b1);
        @(negedge clk);
`ifdef ROM_PREFETCH_STATS_EN
        chk("stat_hits", 32'(stat_hits), 32'd9);
        chk("stat_misses", 32'(stat_misses), 32'd4);
`endif

        // Reset mid-stream: queue dropped, no stop pulse
        tick(); rst_n = 1'b0; drive(1'b0, 12'h000, 1'b0, 8'h00, 1'b0);
        tick(); drive(1'b1, 12'h124, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        chk("midreset_no_stop", 32'(fl_stop), 32'h0);
        chk("midreset_fl_addr", {8'h0, fl_addr}, 32'h0010_0000);
        chk("midreset_queue_dropped", 32'(rom_wait), 32'h1);
        tick(); rst_n = 1'b1; drive(1'b0, 12'h000, 1'b0, 8'h00, 1'b0);
        repeat (2) tick();

        chk("data_queue_drained", 32'(exp_data_q.size()), 32'h0);
        chk("start_queue_drained", 32'(exp_start_q.size()), 32'h0);
        chk("stop_queue_drained", 32'(exp_stop_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
